// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: register offsets, STATUS bit indices and FSM state types   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam logic [1:0] c_reg_txdata = 2'd0;
  localparam logic [1:0] c_reg_rxdata = 2'd1;
  localparam logic [1:0] c_reg_status = 2'd2;

  localparam int c_stat_tx_full   = 0;
  localparam int c_stat_tx_empty  = 1;
  localparam int c_stat_rx_empty  = 2;
  localparam int c_stat_rx_full   = 3;
  localparam int c_stat_overrun   = 4;
  localparam int c_stat_frame_err = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// +----------------------------------------------------------------------+
// | uart_fifo: synchronous show-ahead FIFO, extra pointer bit for full   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot this cycle, so a push into a full FIFO may proceed.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio.sv
// +----------------------------------------------------------------------+
// | uart_mmio: memory-mapped 8N1 UART with TX/RX FIFOs and sticky status |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_mmio #(
  parameter int CLOCK_FREQ       = 25000000,
  parameter int BIT_RATE         = 9600,
  parameter int UART_BUFFER_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic        rx,
  output logic        tx
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Bus side
  logic        r_ack;
  logic [31:0] r_data;
  logic        w_accept;
  logic        w_is_wr;
  logic [1:0]  w_reg;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;
  logic        w_stat_clr;
  logic        w_unused_bits;

  // FIFO side
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0] w_tx_rdata;
  logic       w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0] w_rx_rdata;

  // TX FSM
  tx_state_t        r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx;

  // RX FSM
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic             r_rx_push;
  logic             r_overrun;
  logic             r_frame_err;

  assign w_unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};

  // Simultaneous read and write requests are handled as a write.
  assign w_accept   = ~r_ack & (rd_en_i | wr_en_i);
  assign w_is_wr    = wr_en_i;
  assign w_reg      = addr_i[3:2];
  assign w_tx_push  = w_accept & w_is_wr & (w_reg == c_reg_txdata);
  assign w_stat_clr = w_accept & w_is_wr & (w_reg == c_reg_status);
  assign w_rx_pop   = w_accept & ~w_is_wr & (w_reg == c_reg_rxdata) & ~w_rx_empty;

  always_comb begin
    w_status                   = '0;
    w_status[c_stat_tx_full]   = w_tx_full;
    w_status[c_stat_tx_empty]  = w_tx_empty;
    w_status[c_stat_rx_empty]  = w_rx_empty;
    w_status[c_stat_rx_full]   = w_rx_full;
    w_status[c_stat_overrun]   = r_overrun;
    w_status[c_stat_frame_err] = r_frame_err;
  end

  always_comb begin
    w_rd_data = '0;
    if (!w_is_wr) begin
      case (w_reg)
        c_reg_rxdata: if (!w_rx_empty) w_rd_data = {24'b0, w_rx_rdata};
        c_reg_status: w_rd_data = w_status;
        default:      w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack  <= 1'b0;
      r_data <= '0;
    end else begin
      r_ack  <= w_accept;
      r_data <= w_accept ? w_rd_data : '0;
    end
  end

  assign ack_o  = r_ack;
  assign data_o = r_data;

  uart_fifo #(.WIDTH(8), .DEPTH(UART_BUFFER_SIZE)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .wdata (data_i[7:0]),
    .rdata (w_tx_rdata),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(UART_BUFFER_SIZE)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_rx_push),
    .pop   (w_rx_pop),
    .wdata (r_rx_shift),
    .rdata (w_rx_rdata),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  // Load a new frame from idle, or straight out of the last stop-bit cycle.
  assign w_tx_pop = ~w_tx_empty &
                    ((r_tx_state == TX_IDLE) ||
                     ((r_tx_state == TX_STOP) && (r_tx_cnt == c_cnt_last)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_START: r_tx <= 1'b0;
        TX_DATA:  r_tx <= r_tx_shift[0];
        default:  r_tx <= 1'b1;
      endcase

      if (w_tx_pop) begin
        r_tx_shift <= w_tx_rdata;
        r_tx_cnt   <= '0;
        r_tx_state <= TX_START;
      end else begin
        case (r_tx_state)
          TX_IDLE: r_tx_cnt <= '0;
          TX_START: begin
            if (r_tx_cnt == c_cnt_last) begin
              r_tx_cnt   <= '0;
              r_tx_bit   <= '0;
              r_tx_state <= TX_DATA;
            end else begin
              r_tx_cnt <= r_tx_cnt + c_cnt_one;
            end
          end
          TX_DATA: begin
            if (r_tx_cnt == c_cnt_last) begin
              r_tx_cnt   <= '0;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
              if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
            end else begin
              r_tx_cnt <= r_tx_cnt + c_cnt_one;
            end
          end
          TX_STOP: begin
            if (r_tx_cnt == c_cnt_last) begin
              r_tx_cnt   <= '0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_cnt <= r_tx_cnt + c_cnt_one;
            end
          end
          default: r_tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  assign tx = r_tx;

  // Sticky flags share this block so a set in the same cycle overrides a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_push   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_push <= 1'b0;
      if (w_stat_clr) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end

      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == c_cnt_half) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == c_cnt_last) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == c_cnt_last) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (!r_rx_s2)       r_frame_err <= 1'b1;
            else if (w_rx_full) r_overrun   <= 1'b1;
            else                r_rx_push   <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + c_cnt_one;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
